pipelined_addsub_nbit: RTL



---
 rtl/pipelined_addsub_nbit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipelined_addsub_nbit.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES carry-chained
// chunks, one chunk per clock, with per-stage valid bits and a whole-pipeline stall.
module pipelined_addsub_nbit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : gen_cfg_check
    $error("pipelined_addsub_nbit: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  // Subtraction is a + ~b + ~cin, so cin acts as an active-high borrow-in.
  assign b_eff    = sub ? ~b : b;
  assign cin_eff  = cin ^ sub;

  for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
    localparam int LO = gi * CHUNK;
    localparam int HI = LO + CHUNK;

    logic             vld_in;
    logic             c_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic [HI-1:0]    res_next;
    logic             valid_reg;
    logic             carry_reg;
    logic [HI-1:0]    res_reg;

    if (gi == 0) begin : gen_head
      assign vld_in   = accept;
      assign c_in     = cin_eff;
      assign a_chunk  = a[CHUNK-1:0];
      assign b_chunk  = b_eff[CHUNK-1:0];
      assign res_next = s_chunk;
    end else begin : gen_body
      assign vld_in   = gen_stage[gi-1].valid_reg;
      assign c_in     = gen_stage[gi-1].carry_reg;
      assign a_chunk  = gen_stage[gi-1].gen_ops.opa_reg[HI-1:LO];
      assign b_chunk  = gen_stage[gi-1].gen_ops.opb_reg[HI-1:LO];
      assign res_next = {s_chunk, gen_stage[gi-1].res_reg};
    end

    assign {c_out, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_in};

    // Data registers only load on a valid op, so bubbles leave the last result visible.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        carry_reg <= 1'b0;
        res_reg   <= '0;
      end else if (!stall) begin
        valid_reg <= vld_in;
        if (vld_in) begin
          carry_reg <= c_out;
          res_reg   <= res_next;
        end
      end
    end

    // Operand bits not yet consumed travel alongside the partial result (skew).
    if (gi < STAGES - 1) begin : gen_ops
      logic [WIDTH-1:HI] opa_next;
      logic [WIDTH-1:HI] opb_next;
      logic [WIDTH-1:HI] opa_reg;
      logic [WIDTH-1:HI] opb_reg;

      if (gi == 0) begin : gen_src_in
        assign opa_next = a[WIDTH-1:HI];
        assign opb_next = b_eff[WIDTH-1:HI];
      end else begin : gen_src_prev
        assign opa_next = gen_stage[gi-1].gen_ops.opa_reg[WIDTH-1:HI];
        assign opb_next = gen_stage[gi-1].gen_ops.opb_reg[WIDTH-1:HI];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          opa_reg <= '0;
          opb_reg <= '0;
        end else if (!stall && vld_in) begin
          opa_reg <= opa_next;
          opb_reg <= opb_next;
        end
      end
    end

    if (gi == STAGES - 1) begin : gen_tail
      logic ovf_next;
      logic ovf_reg;

      // a^b^s at the MSB recovers the carry into the MSB; XOR with carry-out gives overflow.
      assign ovf_next = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1] ^ c_out;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (!stall && vld_in) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign out_valid = gen_stage[STAGES-1].valid_reg;
  assign sum       = gen_stage[STAGES-1].res_reg;
  assign cout      = gen_stage[STAGES-1].carry_reg;
  assign ovf       = gen_stage[STAGES-1].gen_tail.ovf_reg;

endmodule
